fpu_imem_responder: RTL and testbench

Instruction-memory responder for the FPU sequencer's fetch interface. Each `Memory_Activation` strobe carries a byte-addressed `PC`. The block answers with the 32-bit instruction word after a fixed, parameterised latency. A preload write port, driven by the management SoC, fills the instruction store before or between programs. Fault and overrun flags report illegal fetches to software.

---
 rtl/fpu_imem_pkg.sv | 20 ++
 rtl/fpu_imem_array.sv | 25 ++
 rtl/fpu_imem_responder.sv | 121 ++++++++++++
 tb/tb_fpu_imem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_imem_pkg.sv
// Shared types and constants for the FPU sequencer's instruction-memory responder.
package fpu_imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Out-of-range fetches return this word, which sends the sequencer back to PC 0.
    localparam logic [31:0] RESTART_WORD = 32'h0000_0010;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    function automatic bit lat_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/fpu_imem_array.sv
// DEPTH x 32 instruction store: one synchronous write port, one combinational read port.
module fpu_imem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    // Contents are deliberately not reset so preloaded programs survive a reset.
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fpu_imem_responder.sv
// Fetch responder: latches a byte PC, waits LAT cycles, returns the instruction word,
// and flags misaligned/out-of-range fetches and requests made while busy.
module fpu_imem_responder
    import fpu_imem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LAT   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          Memory_Activation,
    input  logic [31:0]   PC,
    output logic [31:0]   Instruction,
    output logic          Instr_valid,
    output logic          Busy,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic          load_ready,
    output logic          Fault,
    output logic          Overrun
);

    if (!lat_legal(LAT)) begin : g_lat_illegal
        $error("fpu_imem_responder: LAT must be within 1..4");
    end

    // WAIT exits when the counter has run down from LAT-2, giving LAT edges in total.
    localparam logic [1:0] CNT_INIT = 2'((LAT > 1) ? (LAT - 2) : 0);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        busy_q;
    logic        fault_q;
    logic        ovr_q;

    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        pc_misaligned;
    logic        pc_out_of_range;
    logic [31:0] resp_word;

    assign load_ready      = (state_q == IDLE) & ~Memory_Activation;
    assign mem_we          = load_en & load_ready;
    assign pc_misaligned   = (pc_q[1:0] != 2'b00);
    assign pc_out_of_range = (pc_q[31:AW+2] != '0);
    assign resp_word       = pc_out_of_range ? RESTART_WORD : mem_rdata;

    fpu_imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Memory_Activation) begin
                        pc_q   <= PC;
                        busy_q <= 1'b1;
                        if (LAT == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (Memory_Activation) ovr_q <= 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    // A request arriving here is still dropped: the response is not yet out.
                    if (Memory_Activation) ovr_q <= 1'b1;
                    if (pc_misaligned || pc_out_of_range) fault_q <= 1'b1;
                    instr_q <= resp_word;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Instruction = instr_q;
    assign Instr_valid = valid_q;
    assign Busy        = busy_q;
    assign Fault       = fault_q;
    assign Overrun     = ovr_q;

endmodule

// File: tb/tb_fpu_imem_responder.sv
// Bench for fpu_imem_responder: two instances (LAT=1 and LAT=3) on shared stimulus,
// checked every cycle against a request-countdown model plus hand-computed literals.
module tb_fpu_imem_responder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          ma;
    logic [31:0]   pc;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    logic [31:0] instr1, instr3;
    logic        valid1, valid3, busy1, busy3, ready1, ready3;
    logic        fault1, fault3, ovr1, ovr3;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    int vcnt1    = 0;
    int vcnt3    = 0;

    always #5 clk = ~clk;

    fpu_imem_responder #(.DEPTH(DEPTH), .LAT(1)) u_dut1 (
        .clk(clk), .rst_l(rst_l), .Memory_Activation(ma), .PC(pc),
        .Instruction(instr1), .Instr_valid(valid1), .Busy(busy1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_ready(ready1), .Fault(fault1), .Overrun(ovr1)
    );

    fpu_imem_responder #(.DEPTH(DEPTH), .LAT(3)) u_dut3 (
        .clk(clk), .rst_l(rst_l), .Memory_Activation(ma), .PC(pc),
        .Instruction(instr3), .Instr_valid(valid3), .Busy(busy3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_ready(ready3), .Fault(fault3), .Overrun(ovr3)
    );

    // Model: index 0 is the LAT=1 instance, index 1 the LAT=3 instance.
    int          m_rem   [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_resp  [2];
    bit          m_valid [2];
    bit          m_fault [2];
    bit          m_pfault[2];
    bit          m_ovr   [2];
    logic [31:0] mm      [2][DEPTH];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always @(posedge clk or negedge rst_l) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_l) begin
                m_rem[k]   = 0;
                m_instr[k] = 32'h0;
                m_valid[k] = 1'b0;
                m_fault[k] = 1'b0;
                m_ovr[k]   = 1'b0;
            end else begin
                m_valid[k] = 1'b0;
                if (m_rem[k] > 0) begin
                    if (ma) m_ovr[k] = 1'b1;
                    m_rem[k] = m_rem[k] - 1;
                    if (m_rem[k] == 0) begin
                        m_instr[k] = m_resp[k];
                        m_valid[k] = 1'b1;
                        if (m_pfault[k]) m_fault[k] = 1'b1;
                    end
                end else if (ma) begin
                    m_rem[k]    = lat_of(k);
                    m_resp[k]   = (pc >= 32'(DEPTH * 4)) ? 32'h10 : mm[k][pc / 4 % DEPTH];
                    m_pfault[k] = (pc >= 32'(DEPTH * 4)) || (pc % 4 != 0);
                end else if (load_en) begin
                    mm[k][load_addr] = load_data;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic [31:0] ins, input logic v, input logic b,
                       input logic r, input logic f, input logic o);
        int l;
        l = lat_of(k);
        chk($sformatf("Instruction_lat%0d", l), ins, m_instr[k]);
        chk($sformatf("Instr_valid_lat%0d", l), {31'b0, v}, {31'b0, m_valid[k]});
        chk($sformatf("Busy_lat%0d", l), {31'b0, b}, {31'b0, m_rem[k] > 0});
        chk($sformatf("load_ready_lat%0d", l), {31'b0, r}, {31'b0, (m_rem[k] == 0) && !ma});
        chk($sformatf("Fault_lat%0d", l), {31'b0, f}, {31'b0, m_fault[k]});
        chk($sformatf("Overrun_lat%0d", l), {31'b0, o}, {31'b0, m_ovr[k]});
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, instr1, valid1, busy1, ready1, fault1, ovr1);
            cmp(1, instr3, valid3, busy3, ready3, fault3, ovr3);
            if (valid1 === 1'b1) vcnt1++;
            if (valid3 === 1'b1) vcnt3++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic fetch(input logic [31:0] addr);
        step();
        ma = 1'b1;
        pc = addr;
        step();
        ma = 1'b0;
    endtask

    int v1_before, v3_before;

    initial begin
        rst_l     = 1'b0;
        ma        = 1'b0;
        pc        = 32'h0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = 32'h0;
        repeat (2) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_Instruction", instr3, 32'h0);
        chk("reset_Busy", {31'b0, busy3}, 32'h0);
        step();
        rst_l = 1'b1;

        // Preload words 0..3 with their own index.
        for (int i = 0; i < 4; i++) begin
            step();
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = 32'(i);
        end
        step();
        load_en = 1'b0;

        fetch(32'h8);
        idle(5);
        chk("fetch8_lat1", instr1, 32'h2);
        chk("fetch8_lat3", instr3, 32'h2);
        chk("fetch8_pulses_lat1", 32'(vcnt1), 32'd1);
        chk("fetch8_pulses_lat3", 32'(vcnt3), 32'd1);

        // Request at t, second request at t+1 is dropped.
        step();
        ma = 1'b1;
        pc = 32'h4;
        step();
        pc = 32'h8;
        step();
        ma = 1'b0;
        idle(5);
        chk("overrun_resp_lat3", instr3, 32'h1);
        chk("overrun_flag_lat3", {31'b0, ovr3}, 32'h1);
        chk("overrun_resp_lat1", instr1, 32'h1);

        fetch(32'h400);
        idle(5);
        chk("oor_restart_lat3", instr3, 32'h10);
        chk("oor_fault_lat3", {31'b0, fault3}, 32'h1);

        fetch(32'h6);
        idle(5);
        chk("misaligned_word_lat1", instr1, 32'h1);
        chk("misaligned_word_lat3", instr3, 32'h1);

        // Reset while the LAT=3 instance sits in WAIT.
        v1_before = vcnt1;
        v3_before = vcnt3;
        fetch(32'hC);
        rst_l = 1'b0;
        @(negedge clk);
        chk("midreset_Busy_lat3", {31'b0, busy3}, 32'h0);
        chk("midreset_Instruction_lat3", instr3, 32'h0);
        chk("midreset_flags_lat3", {30'b0, fault3, ovr3}, 32'h0);
        idle(2);
        rst_l = 1'b1;
        idle(6);
        chk("midreset_no_valid_lat1", 32'(vcnt1 - v1_before), 32'h0);
        chk("midreset_no_valid_lat3", 32'(vcnt3 - v3_before), 32'h0);

        // Request and load in the same idle cycle: request wins, write waits.
        step();
        ma        = 1'b1;
        pc        = 32'h8;
        load_en   = 1'b1;
        load_addr = AW'(2);
        load_data = 32'hCAFE_0002;
        @(negedge clk);
        chk("collide_ready_lat1", {31'b0, ready1}, 32'h0);
        chk("collide_ready_lat3", {31'b0, ready3}, 32'h0);
        step();
        ma = 1'b0;
        idle(5);
        load_en = 1'b0;
        idle(2);
        chk("collide_old_word_lat1", instr1, 32'h2);
        chk("collide_old_word_lat3", instr3, 32'h2);

        fetch(32'h8);
        idle(5);
        chk("held_write_lat1", instr1, 32'hCAFE_0002);
        chk("held_write_lat3", instr3, 32'hCAFE_0002);

        fetch(32'hC);
        idle(5);
        chk("survives_reset_lat3", instr3, 32'h3);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
